// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_rate,
                                               input int unsigned baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/uart_rx_vote_if.sv
// Serial-in / word-out signal bundle for the voting UART receiver.
interface uart_rx_vote_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic                 data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output data_in, input data_out, valid, frame_err, busy);
  modport slave  (input data_in, output data_out, valid, frame_err, busy);

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter with restart; flags the three centre samples and the decision cycle.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic sample_strobe,
  output logic decide_strobe
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      bit_cnt <= '0;
    end else if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  always_comb begin
    sample_strobe = (bit_cnt >= CW'(HALF - 1)) && (bit_cnt <= CW'(HALF + 1));
    decide_strobe = (bit_cnt == CW'(HALF + 1));
  end

endmodule

// File: rtl/uart_rx_vote.sv
// UART receiver: two-flop synchroniser, 3-sample majority vote per bit, stop-bit check
// with a break-hold state so a stuck-low line yields a single frame error.
module uart_rx_vote
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(12_000_000, 9600)
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_vote_if.slave  rx
);

  logic                 sync1;
  logic                 rx_s;
  logic [1:0]           samp;
  logic                 vote;
  logic                 sample_strobe;
  logic                 decide_strobe;
  logic                 restart;
  logic                 last_data;
  logic                 last_stop;
  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [4:0]           bit_idx;
  logic                 stop_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx.data_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp <= '1;
    end else if (sample_strobe && !decide_strobe) begin
      samp <= {samp[0], rx_s};
    end
  end

  always_comb begin
    vote      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    last_data = (bit_idx == 5'(DATA_BITS - 1));
    last_stop = (bit_idx == 5'(STOP_BITS - 1));
    // Hold the timer at zero on every path that lands in IDLE, so the first low
    // sample seen there is always bit_cnt 0 even right after an early return.
    restart   = (state == IDLE && rx_s) || (state == BREAK) ||
                (decide_strobe && ((state == START && vote) || (state == STOP && last_stop)));
  end

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .sample_strobe (sample_strobe),
    .decide_strobe (decide_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      stop_err     <= 1'b0;
      rx.data_out  <= '0;
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.busy      <= 1'b0;
    end else begin
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            rx.busy <= 1'b1;
          end
        end
        START: begin
          if (decide_strobe) begin
            bit_idx <= '0;
            if (vote) begin
              state   <= IDLE;
              rx.busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (decide_strobe) begin
            shreg <= (shreg >> 1) | (DATA_BITS'(vote) << (DATA_BITS - 1));
            if (last_data) begin
              bit_idx  <= '0;
              stop_err <= 1'b0;
              state    <= STOP;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        STOP: begin
          if (decide_strobe) begin
            if (last_stop) begin
              rx.data_out <= shreg;
              bit_idx     <= '0;
              stop_err    <= 1'b0;
              if (stop_err || !vote) begin
                rx.frame_err <= 1'b1;
                state        <= BREAK;
              end else begin
                rx.valid <= 1'b1;
                rx.busy  <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              stop_err <= stop_err | ~vote;
              bit_idx  <= bit_idx + 5'd1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            rx.busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_vote.sv
// Bench for uart_rx_vote: three parameterisations, vector table, corner sequences and
// randomized frames checked against an arithmetic timing/decision model.
module tb_uart_rx_vote;

  localparam int KV = 1;
  localparam int KE = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         spike_bit;
    int         hold_low_bits;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic line_a = 1'b1;
  logic line_b = 1'b1;
  logic line_c = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  qa[$];
  ev_t  qb[$];
  ev_t  qc[$];

  uart_rx_vote_if #(.DATA_BITS(8)) ifa ();
  uart_rx_vote_if #(.DATA_BITS(8)) ifb ();
  uart_rx_vote_if #(.DATA_BITS(8)) ifc ();

  assign ifa.data_in = line_a;
  assign ifb.data_in = line_b;
  assign ifc.data_in = line_c;

  uart_rx_vote #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .reset(reset), .rx(ifa));
  uart_rx_vote #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut_b (
    .clk(clk), .reset(reset), .rx(ifb));
  uart_rx_vote #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(5)) dut_c (
    .clk(clk), .reset(reset), .rx(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  task automatic push_exp(input int d, input ev_t e);
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic q_pop(input int d, output ev_t e);
    case (d)
      0:       e = qa.pop_front();
      1:       e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Line edge reaches rx_s two cycles later (t0); the last stop bit is decided HALF+1
  // cycles into it and the pulse shows one cycle after that.
  function automatic int pulse_cycle(input int start, input int cpb, input int nstop);
    return start + 2 + (8 + nstop) * cpb + cpb / 2 + 2;
  endfunction

  function automatic int model_kind(input int stop_bad);
    return (stop_bad != 0) ? KE : KV;
  endfunction

  task automatic send_frame(input int d, input int cpb, input int nstop, input logic [7:0] data,
                            input int stop_low, input int spike_bit, input int hold_low_bits,
                            input int gap, input int exp_kind, input logic [7:0] exp_data);
    ev_t e;
    if (exp_kind != 0) begin
      e.cyc  = pulse_cycle(cyc, cpb, nstop);
      e.kind = exp_kind;
      e.data = exp_data;
      push_exp(d, e);
    end
    for (int b = 0; b < 9 + nstop; b++) begin
      logic v;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else             v = ((b - 9) != stop_low);
      for (int c = 0; c < cpb; c++) begin
        set_line(d, (spike_bit >= 0 && b - 1 == spike_bit && c == cpb / 2) ? ~v : v);
        step();
      end
    end
    set_line(d, 1'b0);
    repeat (hold_low_bits * cpb) step();
    set_line(d, 1'b1);
    repeat (gap) step();
  endtask

  task automatic mon(input int d, input logic v, input logic e, input logic [7:0] dout);
    ev_t x;
    if (v === 1'b1 && e === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL excl dut%0d: valid=1 frame_err=1 at cycle %0d, required at most one", d, cyc);
    end else if (v === 1'b1 || e === 1'b1) begin
      if (q_size(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected dut%0d: valid=%0b frame_err=%0b data=%0h at cycle %0d, required no pulse",
                 d, v, e, dout, cyc);
      end else begin
        q_pop(d, x);
        check($sformatf("pulse_cycle dut%0d", d), cyc, x.cyc);
        check($sformatf("pulse_kind dut%0d", d), (v === 1'b1) ? KV : KE, x.kind);
        check($sformatf("data_out dut%0d", d), dout, x.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, ifa.valid, ifa.frame_err, ifa.data_out);
      mon(1, ifb.valid, ifb.frame_err, ifb.data_out);
      mon(2, ifc.valid, ifc.frame_err, ifc.data_out);
    end
  end

  initial begin
    vec_t vecs[7];
    logic [7:0] mid;
    vecs[0] = '{8'h54, -1, -1,  0, 20, KV, 8'h54};
    vecs[1] = '{8'h00, -1, -1,  0,  0, KV, 8'h00};
    vecs[2] = '{8'hFF, -1, -1,  0,  0, KV, 8'hFF};
    vecs[3] = '{8'hA5, -1, -1,  0, 30, KV, 8'hA5};
    vecs[4] = '{8'h00, -1,  3,  0, 20, KV, 8'h00};
    vecs[5] = '{8'h3C,  0, -1, 40, 20, KE, 8'h3C};
    vecs[6] = '{8'h11, -1, -1,  0, 20, KV, 8'h11};

    reset = 1'b1;
    repeat (4) step();
    check("reset data_out", ifa.data_out, 0);
    check("reset valid", ifa.valid, 0);
    check("reset frame_err", ifa.frame_err, 0);
    check("reset busy", ifa.busy, 0);
    check("reset busy c", ifc.busy, 0);
    reset = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 7; i++) begin
      send_frame(0, 16, 1, vecs[i].data, vecs[i].stop_low, vecs[i].spike_bit,
                 vecs[i].hold_low_bits, vecs[i].gap, vecs[i].exp_kind, vecs[i].exp_data);
    end
    repeat (200) step();
    check("table drained a", q_size(0), 0);

    // One-cycle low glitch: enters START, votes high at the bit centre, returns idle.
    set_line(0, 1'b0);
    step();
    set_line(0, 1'b1);
    step();
    check("glitch busy at t0", ifa.busy, 0);
    step();
    check("glitch busy after t0", ifa.busy, 1);
    repeat (40) step();
    check("glitch busy settled", ifa.busy, 0);

    // Reset during data bit 4 of 0x99, then a clean 0x42.
    mid = 8'h99;
    set_line(0, 1'b0);
    repeat (16) step();
    for (int b = 0; b < 4; b++) begin
      set_line(0, mid[b]);
      repeat (16) step();
    end
    set_line(0, mid[4]);
    repeat (8) step();
    set_line(0, 1'b1);
    reset = 1'b1;
    step();
    check("midreset data_out", ifa.data_out, 0);
    check("midreset valid", ifa.valid, 0);
    check("midreset frame_err", ifa.frame_err, 0);
    check("midreset busy", ifa.busy, 0);
    reset = 1'b0;
    repeat (48) step();
    send_frame(0, 16, 1, 8'h42, -1, -1, 0, 20, KV, 8'h42);

    send_frame(1, 16, 2, 8'h5A, 1, -1, 0, 20, KE, 8'h5A);
    send_frame(1, 16, 2, 8'hC3, -1, -1, 0, 20, KV, 8'hC3);
    send_frame(2, 5, 1, 8'h81, -1, -1, 0, 10, KV, 8'h81);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] byt;
      int bad;
      byt = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
      send_frame(0, 16, 1, byt, bad ? 0 : -1, -1, bad ? int'($urandom_range(0, 3)) : 0,
                 bad ? int'($urandom_range(2, 40)) : int'($urandom_range(0, 40)),
                 model_kind(bad), byt);
    end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] byt;
      int bad;
      byt = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send_frame(2, 5, 1, byt, bad ? 0 : -1, -1, bad ? int'($urandom_range(0, 5)) : 0,
                 bad ? int'($urandom_range(2, 12)) : int'($urandom_range(0, 12)),
                 model_kind(bad), byt);
    end

    repeat (300) step();
    check("drained a", q_size(0), 0);
    check("drained b", q_size(1), 0);
    check("drained c", q_size(2), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
